alu_instr_decoder: RTL and testbench
====================================

ALU_INSTR_DECODER -- requirements
Module: alu_instr_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  producer presents in_data.
REQ-005 in_ready  output  1  block accepts in_data this cycle; transfer = in_valid && in_ready.
REQ-006 in_data  input  8  instruction byte, then operand bytes.
REQ-007 out_valid  output  1  decoded op and operands valid to ALU.
REQ-008 out_ready  input  1  ALU accepts; transfer = out_valid && out_ready.
REQ-009 out_ctrl  output  15  alu_ctrl_t control word.
REQ-010 out_x0, out_x1, out_y0, out_y1  output  8 each  operand bytes.
REQ-011 err  output  1  one-cycle pulse on illegal opcode.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, ISSUE; in_ready = 1 in IDLE and LOAD, 0 in ISSUE; out_valid = 1 only in ISSUE.
REQ-013 In IDLE, an accepted byte SHALL be decoded from opcode = in_data[3:0]; in_data[7:4] ignored.
REQ-014 The decode table SHALL be (opcode: name, out_ctrl, operand count): 0 PASS 15'h0000 0; 1 ADD 15'h5961 4; 2 SUB 15'h79E1 4; 3 MUL 15'h1248 4; 4 SQR 15'h1450 2; 5 DOT 15'h124C 4; 6 CROSS 15'h165E 4.
REQ-015 out_ctrl bit order SHALL be the packed alu_ctrl_t order, MSB first: pre_x_en, pre_x_sub, mul_x_en, mul_x_sel[2:0], pre_y_en, pre_y_sub, mul_y_en, mul_y_sel[2:0], post_en, post_sub, post_sel.
REQ-016 Opcodes 7-15 SHALL be illegal: err = 1 in the cycle after acceptance, state stays IDLE, out_ctrl and operand registers unchanged.
REQ-017 On legal-opcode acceptance, all four operand registers SHALL clear to 0 and out_ctrl SHALL load the table value.
REQ-018 Legal opcode with count 0 SHALL go IDLE -> ISSUE; count > 0 SHALL go IDLE -> LOAD.
REQ-019 In LOAD, accepted bytes SHALL fill operands in order x0, x1, y0, y1 (count 4) or x0, y0 (count 2); a 2-bit counter tracks position; cycles with in_valid = 0 hold state.
REQ-020 The cycle the last operand byte is accepted, state SHALL move LOAD -> ISSUE, giving out_valid = 1 on the next cycle (latency 1 from last byte).
REQ-021 In ISSUE, out_ctrl and all operands SHALL stay stable while out_ready = 0; on transfer, state SHALL return to IDLE next cycle.
REQ-022 No new instruction SHALL be accepted in the ISSUE cycle (no bypass); maximum throughput is one op per count + 2 cycles.

Reset
REQ-023 While rst = 1 at a clock edge: state = IDLE, counter = 0, out_ctrl = 0, operands = 0, out_valid = 0, err = 0.
REQ-024 Reset in LOAD or ISSUE SHALL abandon the operation with no transfer; in_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-025 The opcode enum, the seven control-word constants, and operand-count constants SHALL live in alu_pkg alongside alu_ctrl_t.
REQ-026 The opcode-to-{ctrl, count, legal} table SHALL be a combinational sub-module alu_op_lut; FSM, counter and registers stay in alu_instr_decoder.

Verification
REQ-027 ADD: bytes 0x01, 0x11, 0x22, 0x33, 0x44 back-to-back, out_ready = 1 -> one cycle after 0x44, out_valid = 1, ctrl 15'h5961, x0 = 11, x1 = 22, y0 = 33, y1 = 44 (hex), then IDLE.
REQ-028 SQR: 0x04, 0x05, 0x07 -> ctrl 15'h1450, x0 = 05, y0 = 07, x1 = y1 = 00.
REQ-029 Illegal: 0x09 in IDLE -> err high for exactly one cycle, no out_valid, next byte 0x00 accepted as PASS -> out_valid with ctrl 0, operands 0.
REQ-030 Backpressure: CROSS loaded, out_ready = 0 for 5 cycles -> out_valid and all outputs stable, in_ready = 0; out_ready = 1 -> single transfer.
REQ-031 Bubbles: MUL with in_valid low between each operand -> same result as back-to-back; output one cycle after last byte.
REQ-032 Reset mid-LOAD after 2 of 4 operands -> all outputs 0, in_ready = 1; a fresh DOT then completes correctly with ctrl 15'h124C.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU instruction decoder: opcodes,
// the packed ALU control word, its per-opcode values and operand counts.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS  = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_SQR   = 4'd4,
        OP_DOT   = 4'd5,
        OP_CROSS = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic       pre_x_en;
        logic       pre_x_sub;
        logic       mul_x_en;
        logic [2:0] mul_x_sel;
        logic       pre_y_en;
        logic       pre_y_sub;
        logic       mul_y_en;
        logic [2:0] mul_y_sel;
        logic       post_en;
        logic       post_sub;
        logic       post_sel;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2
    } dec_state_e;

    localparam alu_ctrl_t CTRL_PASS  = 15'h0000;
    localparam alu_ctrl_t CTRL_ADD   = 15'h5961;
    localparam alu_ctrl_t CTRL_SUB   = 15'h79E1;
    localparam alu_ctrl_t CTRL_MUL   = 15'h1248;
    localparam alu_ctrl_t CTRL_SQR   = 15'h1450;
    localparam alu_ctrl_t CTRL_DOT   = 15'h124C;
    localparam alu_ctrl_t CTRL_CROSS = 15'h165E;

    localparam logic [2:0] CNT_PASS  = 3'd0;
    localparam logic [2:0] CNT_ADD   = 3'd4;
    localparam logic [2:0] CNT_SUB   = 3'd4;
    localparam logic [2:0] CNT_MUL   = 3'd4;
    localparam logic [2:0] CNT_SQR   = 3'd2;
    localparam logic [2:0] CNT_DOT   = 3'd4;
    localparam logic [2:0] CNT_CROSS = 3'd4;

endpackage

// File: rtl/alu_op_lut.sv
// Combinational opcode lookup: control word, operand count and legality.
module alu_op_lut
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output alu_ctrl_t  ctrl_o,
    output logic [2:0] cnt_o,
    output logic       legal_o
);

    always_comb begin
        ctrl_o  = CTRL_PASS;
        cnt_o   = CNT_PASS;
        legal_o = 1'b1;
        case (opcode_i)
            OP_PASS:  begin ctrl_o = CTRL_PASS;  cnt_o = CNT_PASS;  end
            OP_ADD:   begin ctrl_o = CTRL_ADD;   cnt_o = CNT_ADD;   end
            OP_SUB:   begin ctrl_o = CTRL_SUB;   cnt_o = CNT_SUB;   end
            OP_MUL:   begin ctrl_o = CTRL_MUL;   cnt_o = CNT_MUL;   end
            OP_SQR:   begin ctrl_o = CTRL_SQR;   cnt_o = CNT_SQR;   end
            OP_DOT:   begin ctrl_o = CTRL_DOT;   cnt_o = CNT_DOT;   end
            OP_CROSS: begin ctrl_o = CTRL_CROSS; cnt_o = CNT_CROSS; end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_instr_decoder.sv
// Byte-stream instruction decoder: collects an opcode plus operand bytes and
// presents one decoded operation to the ALU through a valid/ready handshake.
module alu_instr_decoder
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_ctrl,
    output logic [7:0]  out_x0,
    output logic [7:0]  out_x1,
    output logic [7:0]  out_y0,
    output logic [7:0]  out_y1,
    output logic        err
);

    dec_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    alu_ctrl_t  ctrl_q, ctrl_d;
    logic       err_q, err_d;
    logic [7:0] opnd_q [4];
    logic [7:0] opnd_d [4];

    alu_ctrl_t  lut_ctrl;
    logic [2:0] lut_cnt;
    logic       lut_legal;
    logic [1:0] slot;

    alu_op_lut u_lut (
        .opcode_i (in_data[3:0]),
        .ctrl_o   (lut_ctrl),
        .cnt_o    (lut_cnt),
        .legal_o  (lut_legal)
    );

    // Two-operand ops place their second byte in y0 (slot 2), skipping x1.
    assign slot = (last_q == 2'd1) ? {idx_q[0], 1'b0} : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        ctrl_d  = ctrl_q;
        err_d   = 1'b0;
        opnd_d  = opnd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (lut_legal) begin
                        ctrl_d = lut_ctrl;
                        opnd_d = '{default: 8'h00};
                        idx_d  = 2'd0;
                        last_d = 2'(lut_cnt - 3'd1);
                        state_d = (lut_cnt == 3'd0) ? S_ISSUE : S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    opnd_d[slot] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == last_q) begin
                        idx_d   = 2'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            ctrl_q  <= CTRL_PASS;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_opnd
            always_ff @(posedge clk) begin
                if (rst) begin
                    opnd_q[gi] <= 8'h00;
                end else begin
                    opnd_q[gi] <= opnd_d[gi];
                end
            end
        end
    endgenerate

    assign in_ready  = (state_q != S_ISSUE);
    assign out_valid = (state_q == S_ISSUE);
    assign out_ctrl  = ctrl_q;
    assign out_x0    = opnd_q[0];
    assign out_x1    = opnd_q[1];
    assign out_y0    = opnd_q[2];
    assign out_y1    = opnd_q[3];
    assign err       = err_q;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Scoreboard bench for alu_instr_decoder: directed scenarios plus random
// instruction streams with bubbles and random backpressure.
module tb_alu_instr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_ctrl;
    logic [7:0]  out_x0, out_x1, out_y0, out_y1;
    logic        err;

    alu_instr_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_x0    (out_x0),
        .out_x1    (out_x1),
        .out_y0    (out_y0),
        .out_y1    (out_y1),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [14:0] ctrl;
        logic [7:0]  x0, x1, y0, y1;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          n_xfer = 0;
    bit          rand_done;
    logic [14:0] ctrl_tbl [7] = '{15'h0000, 15'h5961, 15'h79E1, 15'h1248,
                                  15'h1450, 15'h124C, 15'h165E};
    int          cnt_tbl  [7] = '{0, 4, 4, 4, 2, 4, 4};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Phase: called and returns at posedge+#1.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for byte %h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_instr(input logic [7:0] opc, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gap_max);
        exp_t       e;
        int         op = int'(opc[3:0]);
        int         n;
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        send(opc);
        e = '{is_err: 1'b0, ctrl: 15'h0, x0: 8'h0, x1: 8'h0, y0: 8'h0, y1: 8'h0};
        if (op > 6) begin
            e.is_err = 1'b1;
            sb_q.push_back(e);
            $display("[TB] instr %h illegal", opc);
            return;
        end
        n = cnt_tbl[op];
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send(bytes[i]);
        end
        e.ctrl = ctrl_tbl[op];
        if (n == 4) begin
            e.x0 = b0; e.x1 = b1; e.y0 = b2; e.y1 = b3;
        end else if (n == 2) begin
            e.x0 = b0; e.y0 = b1;
        end
        sb_q.push_back(e);
        $display("[TB] instr %h ctrl=%h ops=%h %h %h %h", opc, e.ctrl, e.x0, e.x1, e.y0, e.y1);
    endtask

    task automatic monitor();
        bit          hold = 1'b0;
        logic [46:0] prev = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (err) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL err_unexpected: err=1 with empty scoreboard");
                end else begin
                    e = sb_q.pop_front();
                    chk("err_event_kind", e.is_err, 1'b1);
                end
            end
            if (out_valid) chk("in_ready_in_issue", in_ready, 1'b0);
            if (out_valid && hold)
                chk("issue_stable", {out_ctrl, out_x0, out_x1, out_y0, out_y1}, prev);
            if (out_valid && out_ready) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL xfer_unexpected: transfer with empty scoreboard");
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_kind", e.is_err, 1'b0);
                    chk("xfer_ctrl", out_ctrl, e.ctrl);
                    chk("xfer_ops", {out_x0, out_x1, out_y0, out_y1}, {e.x0, e.x1, e.y0, e.y1});
                end
            end
            hold = out_valid && !out_ready;
            prev = {out_ctrl, out_x0, out_x1, out_y0, out_y1};
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
    endtask

    initial begin
        int x0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, err, out_ctrl, out_x0, out_x1, out_y0, out_y1}, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        out_ready = 1'b1;

        // ADD back-to-back with latency check
        do_instr(8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 0);
        chk("add_latency_valid", out_valid, 1'b1);
        chk("add_ctrl", out_ctrl, 15'h5961);
        chk("add_ops", {out_x0, out_x1, out_y0, out_y1}, 32'h11223344);
        @(posedge clk); #1;
        chk("add_back_idle", in_ready, 1'b1);

        // SQR
        do_instr(8'h04, 8'h05, 8'h07, 8'h00, 8'h00, 0);
        chk("sqr_ctrl", out_ctrl, 15'h1450);
        chk("sqr_ops", {out_x0, out_x1, out_y0, out_y1}, 32'h05000700);
        @(posedge clk); #1;

        // Illegal then PASS
        do_instr(8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        chk("illegal_err_high", err, 1'b1);
        chk("illegal_no_valid", out_valid, 1'b0);
        chk("illegal_ctrl_hold", out_ctrl, 15'h1450);
        do_instr(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        chk("illegal_err_one_cycle", err, 1'b0);
        chk("pass_valid", out_valid, 1'b1);
        chk("pass_outputs", {out_ctrl, out_x0, out_x1, out_y0, out_y1}, '0);
        @(posedge clk); #1;

        // Backpressure on CROSS
        out_ready = 1'b0;
        do_instr(8'h06, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_ctrl", out_ctrl, 15'h165E);
            @(posedge clk); #1;
        end
        x0 = n_xfer;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_single_xfer", n_xfer, x0 + 1);
        chk("bp_valid_drop", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("bp_no_second_xfer", n_xfer, x0 + 1);

        // MUL with bubbles between operands
        do_instr(8'h53, 8'h12, 8'h34, 8'h56, 8'h78, 3);
        chk("bubble_latency_valid", out_valid, 1'b1);
        chk("bubble_ops", {out_x0, out_x1, out_y0, out_y1}, 32'h12345678);
        @(posedge clk); #1;

        // Reset mid-LOAD, then a fresh DOT
        send(8'h03); send(8'hEE); send(8'hDD);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_outputs", {out_valid, err, out_ctrl, out_x0, out_x1, out_y0, out_y1}, '0);
        chk("midreset_in_ready", in_ready, 1'b1);
        do_instr(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 0);
        chk("dot_ctrl", out_ctrl, 15'h124C);
        drain();

        // Random stream with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [3:0] op;
                    logic [3:0] hi;
                    hi = 4'($urandom);
                    op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15))
                                                     : 4'($urandom_range(0, 6));
                    do_instr({hi, op}, 8'($urandom), 8'($urandom), 8'($urandom),
                             8'($urandom), 2);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
